// File: rtl/deser_pkg.sv
// Shared definitions for param_deserializer: FSM state encoding and default word width.
package deser_pkg;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      RECEIVE = 2'd1,
      PARITY  = 2'd2,
      WAIT    = 2'd3
   } state_t;

   localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/deser_shift_reg.sv
// Serial-to-parallel shift register with bit counter; shift direction chosen by MSB_FIRST.
module deser_shift_reg
   import deser_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int MSB_FIRST  = 1
)
(
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_shift,
   input  logic                              i_bit,
   input  logic                              i_clear,
   output logic [DATA_WIDTH-1:0]             o_word,
   output logic [$clog2(DATA_WIDTH+1)-1:0]   o_count
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   logic [DATA_WIDTH-1:0] r_word;
   logic [CNT_W-1:0]      r_count;

   // MSB-first pushes in at bit 0 so the first bit ends at the top after a full word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_word  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_word  <= '0;
         r_count <= '0;
      end else if (i_shift) begin
         if (MSB_FIRST != 0)
            r_word <= {r_word[DATA_WIDTH-2:0], i_bit};
         else
            r_word <= {i_bit, r_word[DATA_WIDTH-1:1]};
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_word  = r_word;
   assign o_count = r_count;

endmodule

// File: rtl/param_deserializer.sv
// Serial bit deserializer with ack handshake and abort; optional even-parity bit
// compiled in with DESER_PARITY_EN.
module param_deserializer
   import deser_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int MSB_FIRST  = 1
)
(
   input  logic                  clock_100KHZ,
   input  logic                  reset,
   input  logic                  data_in,
   input  logic                  write_in,
   input  logic                  ack_in,
   input  logic                  clear_in,
   output logic                  status_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_ready,
   output logic                  parity_err
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_shift;
   logic                  w_clear;
   logic                  w_last_bit;
   logic [DATA_WIDTH-1:0] w_word;
   logic [CNT_W-1:0]      w_count;

   deser_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .MSB_FIRST  (MSB_FIRST)
   ) u_shift (
      .i_clk   (clock_100KHZ),
      .i_rst   (reset),
      .i_shift (w_shift),
      .i_bit   (data_in),
      .i_clear (w_clear),
      .o_word  (w_word),
      .o_count (w_count)
   );

   assign w_last_bit = (w_count == CNT_W'(DATA_WIDTH - 1));

   always_ff @(posedge clock_100KHZ or posedge reset) begin
      if (reset)
         r_state <= INIT;
      else
         r_state <= w_next_state;
   end

   // Priority within every active state: clear_in, then ack_in, then write_in.
   always_comb begin
      w_next_state = r_state;
      w_shift      = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         INIT: begin
            w_next_state = RECEIVE;
         end
         RECEIVE: begin
            if (clear_in) begin
               w_clear = 1'b1;
            end else if (write_in) begin
               w_shift = 1'b1;
               if (w_last_bit) begin
`ifdef DESER_PARITY_EN
                  w_next_state = PARITY;
`else
                  w_next_state = WAIT;
`endif
               end
            end
         end
`ifdef DESER_PARITY_EN
         PARITY: begin
            if (clear_in) begin
               w_clear      = 1'b1;
               w_next_state = RECEIVE;
            end else if (write_in) begin
               w_next_state = WAIT;
            end
         end
`endif
         WAIT: begin
            if (clear_in || ack_in) begin
               w_clear      = 1'b1;
               w_next_state = RECEIVE;
            end
         end
         default: begin
            w_next_state = INIT;
         end
      endcase
   end

`ifdef DESER_PARITY_EN
   logic r_parity_err;

   always_ff @(posedge clock_100KHZ or posedge reset) begin
      if (reset)
         r_parity_err <= 1'b0;
      else if (w_clear)
         r_parity_err <= 1'b0;
      else if (r_state == PARITY && write_in)
         r_parity_err <= (^w_word) ^ data_in;
   end

   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   assign status_out = (r_state != RECEIVE);
   assign data_ready = (r_state == WAIT);
   assign data_out   = w_word;

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, number of bits per word (legal 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the first bit received lands in data_out[DATA_WIDTH-1] and 0 means it lands in data_out[0].
REQ-003 clock_100KHZ  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  1  serial data bit, sampled when write_in is high.
REQ-006 write_in  input  1  one-cycle strobe qualifying data_in.
REQ-007 ack_in  input  1  consumer acknowledges the presented word.
REQ-008 clear_in  input  1  synchronous abort of the current word.
REQ-009 status_out  output  1  0 = ready to accept bits, 1 = busy.
REQ-010 data_out  output  DATA_WIDTH  assembled word.
REQ-011 data_ready  output  1  data_out is valid and awaits ack_in.
REQ-012 parity_err  output  1  parity of the presented word failed; constant 0 when parity is compiled out.

Function
REQ-013 The FSM SHALL have states INIT, RECEIVE, PARITY and WAIT; PARITY is reachable only when parity is compiled in.
REQ-014 INIT SHALL last exactly one cycle with status_out=1, then move to RECEIVE with status_out=0.
REQ-015 In RECEIVE, each cycle with write_in=1 SHALL shift data_in into the word (direction per MSB_FIRST) and increment a bit counter of width $clog2(DATA_WIDTH+1).
REQ-016 The bit completing DATA_WIDTH bits SHALL cause, on the next edge, the full word on data_out, status_out=1, and a move to PARITY (if enabled) or to WAIT with data_ready=1.
REQ-017 data_out SHALL hold stable while data_ready=1; partial words SHALL NOT be visible as valid.
REQ-018 In WAIT, ack_in=1 SHALL, on the next edge, clear data_ready, parity_err, data_out and the counter, set status_out=0 and return to RECEIVE.
REQ-019 write_in in INIT, PARITY-done, or WAIT SHALL be ignored; ack_in outside WAIT SHALL be ignored.
REQ-020 clear_in=1 in any state except INIT SHALL, on the next edge, discard the partial or presented word, clear the counter, data_out, data_ready and parity_err, set status_out=0 and move to RECEIVE.
REQ-021 Priority SHALL be clear_in over ack_in over write_in when asserted in the same cycle.
REQ-022 Back-to-back words SHALL be supported: a write_in on the first cycle after ack_in is accepted as bit 0 of the next word.

Reset
REQ-023 Asserting reset SHALL immediately force state INIT, status_out=1, data_ready=0, data_out=0, parity_err=0 and counter=0, including mid-word and mid-WAIT.
REQ-024 Release of reset SHALL be followed by exactly one INIT cycle before bits are accepted.

Configuration
REQ-025 With DESER_PARITY_EN defined, after DATA_WIDTH data bits the block SHALL accept one more write_in bit in PARITY as an even-parity bit, then enter WAIT with data_ready=1 and parity_err=1 if XOR of word and parity bit is 1.
REQ-026 Without DESER_PARITY_EN, the PARITY state and logic SHALL be absent, parity_err SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
REQ-027 The state_t enum (INIT, RECEIVE, PARITY, WAIT) and the default width constant SHALL live in shared package deser_pkg.
REQ-028 The shift/count datapath SHALL be a sub-module deser_shift_reg parameterised by DATA_WIDTH and MSB_FIRST; the FSM stays in param_deserializer.

Verification
REQ-029 Reset, DATA_WIDTH=8, MSB_FIRST=1, shift bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5, data_ready=1, status_out=1 one edge after the 8th bit.
REQ-030 MSB_FIRST=0, same bit sequence -> data_out=8'hA5 reversed (8'hA5 bit-reversed = 8'hA5 for this pattern; also test bits 1,1,0,0,0,0,0,0 -> 8'h03).
REQ-031 Word held, write_in toggled 5 times in WAIT, then ack_in -> data_out unchanged until ack, then 0, status_out=0 next edge, next word unaffected.
REQ-032 Three bits shifted, then clear_in with write_in=1 same cycle -> counter=0, data_out=0, no bit captured, next 8 bits form a clean word.
REQ-033 DESER_PARITY_EN, word 8'hA5 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
REQ-034 Reset asserted after 5 bits -> all outputs at reset values asynchronously, status_out=1 for one cycle after release, then 0.
